// File: rtl/lockin_demodulator.sv
// In-phase lock-in demodulator: multiplies ADC samples by the sign of a square reference and
// integrates the products over whole reference periods, emitting one saturated result per window.
module lockin_demodulator #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 32,
  parameter int NPER_W = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     ref_in,
  input  logic                     enable,
  input  logic [NPER_W-1:0]        n_periods,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic                     overflow,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Returns {saturated, clamped_sum}; the extra MSB exposes signed overflow of a+b.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      sat_add = s[ACC_W] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  state_t                    state, state_nxt;
  logic                      ref_q, ref_d;
  logic                      rise;
  logic signed [ACC_W-1:0]   samp_ext;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   add_sum;
  logic                      add_ovf;
  logic                      sat_flag;
  logic [NPER_W-1:0]         pcount;
  logic [NPER_W-1:0]         n_lat;
  logic [NPER_W:0]           pcount_inc;
  logic                      last_period;
  logic                      start_win;
  logic                      do_add;
  logic                      emit;

  assign rise        = ref_q & ~ref_d;
  assign samp_ext    = ACC_W'(sample_data);
  assign prod        = !sample_valid ? '0 : (ref_q ? samp_ext : -samp_ext);
  assign {add_ovf, add_sum} = sat_add(acc, prod);
  assign pcount_inc  = {1'b0, pcount} + {{NPER_W{1'b0}}, 1'b1};
  assign last_period = (pcount_inc == {1'b0, n_lat});

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping enable always wins over a window completing in the same cycle.
  always_comb begin
    state_nxt = state;
    start_win = 1'b0;
    do_add    = 1'b0;
    emit      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (enable) state_nxt = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (rise) begin
          start_win = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (rise && last_period) begin
          emit      = 1'b1;
          start_win = 1'b1;
        end else begin
          do_add = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The sample on the rise cycle seeds the new window; the closed window excludes it.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ref_q        <= 1'b0;
      ref_d        <= 1'b0;
      acc          <= '0;
      sat_flag     <= 1'b0;
      pcount       <= '0;
      n_lat        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      ref_q        <= ref_in;
      ref_d        <= ref_q;
      result_valid <= emit;
      if (state == ARM && start_win) begin
        n_lat <= (n_periods == '0) ? NPER_W'(1) : n_periods;
      end
      if (emit) begin
        result   <= acc;
        overflow <= sat_flag;
      end
      if (start_win) begin
        acc      <= prod;
        sat_flag <= 1'b0;
        pcount   <= '0;
      end else if (do_add) begin
        acc <= add_sum;
        if (add_ovf) sat_flag <= 1'b1;
        if (rise) pcount <= pcount_inc[NPER_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_lockin_demodulator.sv
// Bench for lockin_demodulator: directed reference/sample patterns with a queue of expected
// window results; a 32-bit instance covers the main function, a 16-bit one the saturation case.
module tb_lockin_demodulator;

  localparam int DATA_W = 12;
  localparam int NPER_W = 8;

  logic                     clk_in = 1'b0;
  logic                     rst_n;
  logic                     ref_in;
  logic                     enable;
  logic                     enable16;
  logic [NPER_W-1:0]        n_periods;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_data;

  logic signed [31:0] result;
  logic               result_valid, overflow, busy;
  logic signed [15:0] result16;
  logic               result_valid16, overflow16, busy16;

  lockin_demodulator #(.DATA_W(DATA_W), .ACC_W(32), .NPER_W(NPER_W)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .ref_in(ref_in), .enable(enable),
    .n_periods(n_periods), .sample_valid(sample_valid), .sample_data(sample_data),
    .result(result), .result_valid(result_valid), .overflow(overflow), .busy(busy)
  );

  lockin_demodulator #(.DATA_W(DATA_W), .ACC_W(16), .NPER_W(NPER_W)) dut16 (
    .clk_in(clk_in), .rst_n(rst_n), .ref_in(ref_in), .enable(enable16),
    .n_periods(n_periods), .sample_valid(sample_valid), .sample_data(sample_data),
    .result(result16), .result_valid(result_valid16), .overflow(overflow16), .busy(busy16)
  );

  always #5 clk_in = ~clk_in;

  int cyc_n = 0;
  always @(posedge clk_in) cyc_n <= cyc_n + 1;

  typedef struct {
    logic signed [31:0] res;
    logic               ovf;
    bit                 chk16;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];

  int       checks = 0;
  int       errors = 0;
  int       cur_mode = 0;
  int       cur_amp  = 0;
  bit       cur_alt  = 1'b0;
  bit       tog      = 1'b0;
  logic [3:0] hist   = 4'b0;
  int       last_rise_cyc = -100;
  int       arm_rise_cyc  = -100;
  bit       mark_arm = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push32(input logic signed [31:0] r, input logic o, input bit c);
    exp_t e;
    e.res = r; e.ovf = o; e.chk16 = c;
    q32.push_back(e);
  endtask

  task automatic push16(input logic signed [31:0] r, input logic o);
    exp_t e;
    e.res = r; e.ovf = o; e.chk16 = 1'b0;
    q16.push_back(e);
  endtask

  // Compares every result strobe against the next queued window value.
  task automatic monitor();
    exp_t e;
    if (result_valid === 1'b1) begin
      chk("unexpected_result32", q32.size() != 0, 1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("result32", result, e.res);
        chk("overflow32", overflow, e.ovf);
        chk("latency32", cyc_n - last_rise_cyc, 2);
        if (e.chk16) chk("rearm_latency", cyc_n - arm_rise_cyc, 18);
      end
    end
    if (result_valid16 === 1'b1) begin
      chk("unexpected_result16", q16.size() != 0, 1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        chk("result16", result16, 16'(e.res));
        chk("overflow16", overflow16, e.ovf);
        chk("latency16", cyc_n - last_rise_cyc, 2);
      end
    end
  endtask

  // hist[0] is the reference the DUT holds in ref_q when this cycle's sample is taken.
  task automatic drive_cycle(input logic r);
    int d;
    @(negedge clk_in);
    monitor();
    case (cur_mode)
      0:       d = cur_amp;
      1:       d = hist[0] ? cur_amp : -cur_amp;
      2:       d = hist[2] ? cur_amp : -cur_amp;
      default: d = hist[0] ? 0 : -2048;
    endcase
    sample_valid = cur_alt ? tog : 1'b1;
    tog          = ~tog;
    sample_data  = DATA_W'(d);
    if (r && !hist[0]) begin
      last_rise_cyc = cyc_n;
      if (mark_arm) begin
        arm_rise_cyc = cyc_n;
        mark_arm     = 1'b0;
      end
    end
    ref_in = r;
    hist   = {hist[2:0], r};
  endtask

  task automatic periods(input int cnt, input int half);
    for (int p = 0; p < cnt; p++) begin
      for (int i = 0; i < half; i++) drive_cycle(1'b1);
      for (int i = 0; i < half; i++) drive_cycle(1'b0);
    end
  endtask

  // k windows need k*N periods after the arming rise, plus one more rise to close the last.
  task automatic run_test(input int n, input int mode, input int amp, input bit alt,
                          input int k, input int exp_res);
    n_periods = NPER_W'(n);
    cur_mode  = mode;
    cur_amp   = amp;
    cur_alt   = alt;
    enable    = 1'b1;
    for (int i = 0; i < k; i++) push32(exp_res, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0);
    chk("busy_armed", busy, 1);
    periods(k * ((n == 0) ? 1 : n) + 1, 4);
    enable = 1'b0;
    repeat (3) drive_cycle(1'b0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; enable16 = 1'b0; ref_in = 1'b0;
    sample_valid = 1'b0; sample_data = '0; n_periods = 8'd1;

    // Reset held with random inputs
    repeat (16) begin
      @(negedge clk_in);
      chk("rst_result", result, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result16", result16, 0);
      chk("rst_valid16", result_valid16, 0);
      chk("rst_overflow16", overflow16, 0);
      chk("rst_busy16", busy16, 0);
      ref_in       = 1'($urandom_range(0, 1));
      enable       = 1'($urandom_range(0, 1));
      enable16     = 1'($urandom_range(0, 1));
      sample_valid = 1'($urandom_range(0, 1));
      sample_data  = DATA_W'($urandom);
      n_periods    = NPER_W'($urandom);
    end
    @(negedge clk_in);
    rst_n = 1'b1; enable = 1'b0; enable16 = 1'b0; ref_in = 1'b0; sample_valid = 1'b0;
    hist = 4'b0;
    repeat (2) drive_cycle(1'b0);

    // Constant input cancels over whole periods
    run_test(1, 0, 100, 1'b0, 3, 0);
    // In-phase and quadrature data, two periods per window
    run_test(2, 1, 100, 1'b0, 2, 1600);
    run_test(2, 2, 100, 1'b0, 2, 0);

    // Saturation on the 16-bit instance, then a clean window
    n_periods = 8'd1; cur_mode = 1; cur_amp = 2047; cur_alt = 1'b0;
    enable16 = 1'b1;
    push16(32767, 1'b1);
    push16(640, 1'b0);
    repeat (3) drive_cycle(1'b0);
    chk("busy16_armed", busy16, 1);
    periods(1, 32);
    cur_amp = 10;
    periods(2, 32);
    enable16 = 1'b0;
    repeat (3) drive_cycle(1'b0);
    chk("busy16_idle", busy16, 0);
    chk("result16_hold", result16, 640);
    chk("overflow16_hold", overflow16, 0);
    chk("result32_untouched", result, 0);

    // Abort mid-window, then re-arm
    n_periods = 8'd2; cur_mode = 1; cur_amp = 100; cur_alt = 1'b0;
    enable = 1'b1;
    push32(1600, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0);
    periods(3, 4);
    for (int i = 0; i < 6; i++) drive_cycle(i < 4);
    enable = 1'b0;
    drive_cycle(1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_result_hold", result, 1600);
    chk("abort_overflow_hold", overflow, 0);
    repeat (3) drive_cycle(1'b0);
    enable = 1'b1;
    push32(1600, 1'b0, 1'b1);
    mark_arm = 1'b1;
    repeat (3) drive_cycle(1'b0);
    periods(3, 4);
    enable = 1'b0;
    repeat (3) drive_cycle(1'b0);

    // n_periods=0 acts as 1; half-rate valid; most negative sample negated exactly
    run_test(0, 1, 100, 1'b0, 2, 800);
    run_test(2, 1, 100, 1'b1, 2, 800);
    run_test(1, 3, 0, 1'b0, 2, 8192);

    // Reset in the middle of a window clears everything and emits nothing
    n_periods = 8'd2; cur_mode = 1; cur_amp = 100; cur_alt = 1'b0;
    enable = 1'b1;
    repeat (3) drive_cycle(1'b0);
    periods(1, 4);
    drive_cycle(1'b1);
    rst_n = 1'b0;
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    chk("midrst_result", result, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    rst_n  = 1'b1;
    enable = 1'b0;
    repeat (4) drive_cycle(1'b0);

    chk("q32_drained", q32.size(), 0);
    chk("q16_drained", q16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
